// File: rtl/rs_pkg.sv
// Shared definitions for the R*s symbol slicer: fixed 8-QAM constellation,
// slicer FSM states and the candidate count.
package rs_pkg;

    localparam int NUM_SYM = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Real axis 2*s[1:0]-3 -> {-3,-1,1,3}; the bit pattern is {~s1, s0, 1}.
    function automatic logic signed [2:0] sym_re(input logic [1:0] s_lo);
        return $signed({~s_lo[1], s_lo[0], 1'b1});
    endfunction

    // Imaginary axis 2*s[2]-1 -> {-1,1}.
    function automatic logic signed [2:0] sym_im(input logic s_hi);
        return s_hi ? 3'sb001 : 3'sb111;
    endfunction

endpackage

// File: rtl/rs_multiplier.sv
// Combinational complex product R*s for one constellation index, kept at
// full precision (WIDTH+3 bits per component).
module rs_multiplier
    import rs_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] r_real,
    input  logic signed [WIDTH-1:0] r_imag,
    input  logic        [2:0]       sym,
    output logic signed [WIDTH+2:0] p_real,
    output logic signed [WIDTH+2:0] p_imag
);

    localparam int PW = WIDTH + 3;

    logic signed [2:0]    s_re;
    logic signed [2:0]    s_im;
    logic signed [PW-1:0] rr;
    logic signed [PW-1:0] ri;
    logic signed [PW-1:0] re;
    logic signed [PW-1:0] im;

    assign s_re = sym_re(sym[1:0]);
    assign s_im = sym_im(sym[2]);

    assign rr = {{3{r_real[WIDTH-1]}}, r_real};
    assign ri = {{3{r_imag[WIDTH-1]}}, r_imag};
    assign re = {{WIDTH{s_re[2]}}, s_re};
    assign im = {{WIDTH{s_im[2]}}, s_im};

    // |Rr*re| + |Ri*im| <= 2^(WIDTH+1), so PW bits never wrap.
    assign p_real = rr * re - ri * im;
    assign p_imag = rr * im + ri * re;

endmodule

// File: rtl/rs_symbol_slicer.sv
// Sequential nearest-symbol search: one 8-QAM candidate per clock, returns
// the index minimising |Y - R*s|^2 and that distance.
module rs_symbol_slicer
    import rs_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DWIDTH = 2*WIDTH + 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] R_real,
    input  logic signed [WIDTH-1:0] R_imag,
    input  logic signed [WIDTH-1:0] Y_real,
    input  logic signed [WIDTH-1:0] Y_imag,
    output logic                    busy,
    output logic                    done,
    output logic [2:0]              S_hat,
    output logic [DWIDTH-1:0]       Dist_min,
    output state_t                  dbg_state
);

    localparam int EW = WIDTH + 4;
    localparam int SW = 2 * EW;
    localparam logic [2:0] LAST_IDX = 3'(NUM_SYM - 1);

    state_t                   state_q, state_d;
    logic signed [WIDTH-1:0]  r_re_q, r_im_q, y_re_q, y_im_q;
    logic [2:0]               idx_q;
    logic [DWIDTH-1:0]        best_d_q;
    logic [2:0]               best_s_q;
    logic [2:0]               s_hat_q;
    logic [DWIDTH-1:0]        dist_q;

    logic signed [WIDTH+2:0]  p_real, p_imag;
    logic signed [EW-1:0]     e_re, e_im;
    logic signed [SW-1:0]     e_re_w, e_im_w;
    logic [SW-1:0]            d_full;
    logic [SW-1:0]            best_d_ext;
    logic [DWIDTH-1:0]        d_cur;
    logic                     better;

    rs_multiplier #(.WIDTH(WIDTH)) u_mult (
        .r_real (r_re_q),
        .r_imag (r_im_q),
        .sym    (idx_q),
        .p_real (p_real),
        .p_imag (p_imag)
    );

    assign e_re   = {{4{y_re_q[WIDTH-1]}}, y_re_q} - {p_real[WIDTH+2], p_real};
    assign e_im   = {{4{y_im_q[WIDTH-1]}}, y_im_q} - {p_imag[WIDTH+2], p_imag};
    assign e_re_w = {{EW{e_re[EW-1]}}, e_re};
    assign e_im_w = {{EW{e_im[EW-1]}}, e_im};

    // Squares are taken at double error width; the sum always fits DWIDTH.
    assign d_full     = e_re_w * e_re_w + e_im_w * e_im_w;
    assign best_d_ext = {{(SW-DWIDTH){1'b0}}, best_d_q};
    assign d_cur      = d_full[DWIDTH-1:0];
    // Strict compare: the lowest index wins among equal distances.
    assign better     = d_full < best_d_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SEARCH;
            SEARCH:  if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_re_q   <= '0;
            r_im_q   <= '0;
            y_re_q   <= '0;
            y_im_q   <= '0;
            idx_q    <= '0;
            best_d_q <= '1;
            best_s_q <= '0;
            s_hat_q  <= '0;
            dist_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        r_re_q   <= R_real;
                        r_im_q   <= R_imag;
                        y_re_q   <= Y_real;
                        y_im_q   <= Y_imag;
                        idx_q    <= '0;
                        best_d_q <= '1;
                        best_s_q <= '0;
                    end
                end
                SEARCH: begin
                    if (better) begin
                        best_d_q <= d_cur;
                        best_s_q <= idx_q;
                    end
                    idx_q <= idx_q + 3'd1;
                    // The last candidate is folded in directly as results load.
                    if (idx_q == LAST_IDX) begin
                        s_hat_q <= better ? idx_q : best_s_q;
                        dist_q  <= better ? d_cur : best_d_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign S_hat     = s_hat_q;
    assign Dist_min  = dist_q;
    assign dbg_state = state_q;

endmodule
